// File: rtl/viterbi_pkg.sv
// Shared constants and types for the Viterbi front end (input FIFO and symbol serializer).
package viterbi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } piso_state_t;

  localparam int FIFO_WIDTH = 16;
  localparam int SYM_W      = 2;
  localparam int N          = FIFO_WIDTH / SYM_W;

endpackage

// File: rtl/piso_serializer.sv
// Pops words from the input FIFO and emits them as SYM_W-bit code symbols on a
// valid/ready stream, flagging the last symbol of each word.
module piso_serializer
  import viterbi_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int SYM_W     = viterbi_pkg::SYM_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic [SYM_W-1:0] sym_o,
  output logic             sym_valid_o,
  input  logic             sym_ready_i,
  output logic             sym_last_o,
  output logic             busy_o
);

  localparam int N     = WIDTH / SYM_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  piso_state_t      state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             hs;
  logic [SYM_W-1:0] sym_head;
  logic [WIDTH-1:0] shreg_shifted;

  assign cnt_last = (cnt == CNT_W'(N - 1));
  assign hs       = sym_valid_o && sym_ready_i;

  // The emitting end is the MSB side or the LSB side; the vacated end is zero-filled.
  assign sym_head      = MSB_FIRST ? shreg[WIDTH-1 -: SYM_W] : shreg[SYM_W-1:0];
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-SYM_W-1:0], {SYM_W{1'b0}}}
                                   : {{SYM_W{1'b0}}, shreg[WIDTH-1:SYM_W]};

  always_comb begin
    state_nxt   = state;
    fifo_rd_en  = 1'b0;
    sym_valid_o = 1'b0;
    sym_last_o  = 1'b0;
    sym_o       = '0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_nxt  = WAIT;
        end
      end
      WAIT: state_nxt = SHIFT;
      SHIFT: begin
        sym_valid_o = 1'b1;
        sym_o       = sym_head;
        sym_last_o  = cnt_last;
        // Prefetch the next word on the final handshake so only one bubble is paid per word.
        if (sym_ready_i && cnt_last) begin
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            state_nxt  = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) begin
      state_nxt  = IDLE;
      fifo_rd_en = 1'b0;
    end
    // Outputs read as zero while reset is held, so no pop can be lost to a reset.
    if (rst) begin
      fifo_rd_en  = 1'b0;
      sym_valid_o = 1'b0;
      sym_last_o  = 1'b0;
      sym_o       = '0;
    end
  end

  assign busy_o = (state != IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (flush_i) begin
        cnt <= '0;
      end else begin
        unique case (state)
          WAIT: begin
            shreg <= fifo_dout;
            cnt   <= '0;
          end
          SHIFT: begin
            if (hs && !cnt_last) begin
              shreg <= shreg_shifted;
              cnt   <= cnt + CNT_W'(1);
            end else if (hs) begin
              cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: FIFO model, symbol-stream reference model, directed and random traffic.
module tb_piso_serializer;
  import viterbi_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush_i;
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_dout;
  logic                  sym_ready_i;
  logic                  rd0, v0, l0, b0;
  logic [SYM_W-1:0]      s0;
  logic                  rd1, v1, l1, b1;
  logic [SYM_W-1:0]      s1;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(FIFO_WIDTH), .SYM_W(SYM_W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .flush_i(flush_i), .fifo_rd_en(rd0), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .sym_o(s0), .sym_valid_o(v0), .sym_ready_i(sym_ready_i),
    .sym_last_o(l0), .busy_o(b0));

  piso_serializer #(.WIDTH(FIFO_WIDTH), .SYM_W(SYM_W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .flush_i(flush_i), .fifo_rd_en(rd1), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .sym_o(s1), .sym_valid_o(v1), .sym_ready_i(sym_ready_i),
    .sym_last_o(l1), .busy_o(b1));

  typedef struct {
    logic [FIFO_WIDTH-1:0] w;
    int                    idx;
  } exp_t;

  int                    n_tests = 0;
  int                    n_fail  = 0;
  int                    cyc     = 0;
  logic [FIFO_WIDTH-1:0] fifo_q[$];
  exp_t                  exp_q[$];
  int                    obs_q[$];
  int                    obs1_q[$];
  int                    pops = 0, done_words = 0, acc_in_word = 0, rd_at_last = 0;
  int                    first_vld = -1, last_hs = -1;
  logic                  rd_latched = 1'b0;
  logic                  pv = 1'b0, pr = 1'b0, pf = 1'b0, prst = 1'b1, pl = 1'b0;
  logic [SYM_W-1:0]      ps = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Symbol idx of word w, counted in emission order.
  function automatic int sym_of(input logic [FIFO_WIDTH-1:0] w, input int idx, input bit msb);
    logic [FIFO_WIDTH-1:0] t;
    t = msb ? (w >> (FIFO_WIDTH - SYM_W * (idx + 1))) : (w >> (SYM_W * idx));
    return int'(t[SYM_W-1:0]);
  endfunction

  task automatic push(input logic [FIFO_WIDTH-1:0] w);
    exp_t e;
    fifo_q.push_back(w);
    for (int i = 0; i < N; i++) begin
      e.w   = w;
      e.idx = i;
      exp_q.push_back(e);
    end
    fifo_empty = 1'b0;
  endtask

  task automatic clear_log();
    obs_q.delete();
    obs1_q.delete();
    first_vld   = -1;
    last_hs     = -1;
    acc_in_word = 0;
  endtask

  // One clock: observe at the falling edge, then advance the FIFO just after the rising edge.
  task automatic step();
    exp_t    e;
    logic    hs;
    int      lsym;
    @(negedge clk);
    if (rd0) chk("rd_while_empty", fifo_empty, 0);
    rd_latched = rd0;
    if (!v0) chk("mask", {s0, l0}, 0);
    if (pv && !pr && !pf && !prst) chk("hold", {v0, s0, l0}, {pv, ps, pl});
    chk("lsb_ctl", {rd1, v1, b1}, {rd0, v0, b0});
    if (v0 && first_vld < 0) first_vld = cyc;
    hs = v0 && sym_ready_i;
    if (hs) begin
      last_hs = cyc;
      if (rd0 && l0) rd_at_last++;
      if (exp_q.size() == 0) begin
        chk("spurious_sym", 1, 0);
      end else begin
        e    = exp_q.pop_front();
        lsym = sym_of(e.w, e.idx, 1'b0);
        chk("sym_msb", s0, sym_of(e.w, e.idx, 1'b1));
        chk("sym_last", l0, (e.idx == N - 1));
        chk("sym_lsb", {v1, s1, l1}, {1'b1, lsym[SYM_W-1:0], (e.idx == N - 1)});
        obs_q.push_back(int'(s0));
        obs1_q.push_back(int'(s1));
        if (e.idx == N - 1) begin
          done_words++;
          acc_in_word = 0;
        end else begin
          acc_in_word++;
        end
      end
    end
    if ((flush_i || rst) && pops > done_words) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.idx == N - 1) break;
      end
      done_words++;
      acc_in_word = 0;
    end
    pv = v0; pr = sym_ready_i; pf = flush_i; prst = rst; ps = s0; pl = l0;
    @(posedge clk);
    cyc++;
    #1;
    if (rd_latched && fifo_q.size() > 0) begin
      fifo_dout = fifo_q.pop_front();
      pops++;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0) return;
      step();
    end
    chk("drain_timeout", 1, 0);
  endtask

  task automatic wait_acc(input int k);
    for (int i = 0; i < 50; i++) begin
      step();
      if (acc_in_word == k) return;
    end
    chk("acc_timeout", 1, 0);
  endtask

  int t1_msb[8] = '{2, 3, 1, 0, 3, 0, 0, 1};
  int t1_lsb[4] = '{1, 0, 0, 3};
  int t5_msb[4] = '{0, 1, 0, 2};
  int p0, r0, pc;

  initial begin
    rst = 1'b1; flush_i = 1'b0; sym_ready_i = 1'b1; fifo_empty = 1'b1; fifo_dout = '0;
    repeat (3) step();
    chk("rst_outputs", {rd0, v0, l0, b0, s0}, 0);
    rst = 1'b0;
    step();
    chk("post_rst_outputs", {rd0, v0, l0, b0, s0}, 0);

    // Empty FIFO: nothing moves.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("empty_rd", rd0, 0);
      chk("empty_vld", v0, 0);
      chk("empty_busy", b0, 0);
    end

    // Single word, latency and symbol order in both bit orders.
    clear_log(); p0 = pops;
    push(16'hB4C1); pc = cyc;
    wait_drain(60);
    chk("t1_busy_after", b0, 0);
    chk("t1_latency", first_vld - pc, 2);
    chk("t1_pops", pops - p0, 1);
    chk("t1_count", obs_q.size(), 8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) chk("t1_msb_seq", obs_q[i], t1_msb[i]);
    for (int i = 0; i < 4 && i < obs1_q.size(); i++) chk("t1_lsb_seq", obs1_q[i], t1_lsb[i]);

    // Back-to-back words: one bubble, prefetch on the last handshake.
    clear_log(); p0 = pops; r0 = rd_at_last;
    push(16'hFFFF); push(16'h0000);
    wait_drain(80);
    chk("t2_span", last_hs - first_vld + 1, 2 * N + 1);
    chk("t2_pops", pops - p0, 2);
    chk("t2_rd_at_last", rd_at_last - r0, 1);
    chk("t2_count", obs_q.size(), 16);
    for (int i = 0; i < 16 && i < obs_q.size(); i++) chk("t2_seq", obs_q[i], (i < 8) ? 3 : 0);

    // Backpressure while the third symbol is presented.
    clear_log(); p0 = pops;
    push(16'hB4C1);
    wait_acc(2);
    chk("t3_third_sym", {v0, s0}, {1'b1, 2'b01});
    sym_ready_i = 1'b0;
    repeat (3) step();
    sym_ready_i = 1'b1;
    wait_drain(60);
    chk("t3_pops", pops - p0, 1);
    chk("t3_count", obs_q.size(), 8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) chk("t3_seq", obs_q[i], t1_msb[i]);

    // Flush after three accepted symbols, next word queued.
    clear_log();
    push(16'hB4C1); push(16'h1234);
    wait_acc(3);
    sym_ready_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0; sym_ready_i = 1'b1;
    chk("t4_flush_idle", b0, 0);
    wait_drain(60);
    chk("t4_count", obs_q.size(), 3 + N);
    for (int i = 0; i < 4 && i + 3 < obs_q.size(); i++) chk("t4_next_seq", obs_q[i + 3], t5_msb[i]);

    // Reset in the middle of a word.
    clear_log();
    push(16'hB4C1);
    wait_acc(2);
    rst = 1'b1;
    step();
    chk("t5_rst_outputs", {rd0, v0, l0, b0, s0}, 0);
    rst = 1'b0;
    #1;
    chk("t5_after_rst_outputs", {rd0, v0, l0, b0, s0}, 0);
    push(16'h1234);
    wait_drain(60);
    chk("t5_count", obs_q.size(), 2 + N);
    for (int i = 0; i < 4 && i + 2 < obs_q.size(); i++) chk("t5_next_seq", obs_q[i + 2], t5_msb[i]);

    // Random traffic, backpressure and flushes.
    clear_log();
    for (int i = 0; i < 400; i++) begin
      if (fifo_q.size() < 3 && $urandom_range(0, 3) == 0) push(FIFO_WIDTH'($urandom));
      sym_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 39) == 0);
      step();
    end
    flush_i = 1'b0; sym_ready_i = 1'b1;
    wait_drain(400);
    step();
    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_busy", b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
